// File: rtl/pcg32_rng_arbiter.sv
// Shared PCG32 word server: round-robin grants to NUM_REQ requesters plus an srandom reseed sequencer.
// Latency: word appears 1 cycle after gnt; backpressure: requesters hold req until granted, rsp never stalls.
module pcg32_rng_arbiter #(
  parameter int          NUM_REQ   = 4,
  parameter int          ID_W      = 2,
  parameter logic [63:0] MULT      = 64'h5851f42d4c957f2d,
  parameter logic [63:0] RST_STATE = 64'h853c49e6748fea9b,
  parameter logic [63:0] RST_INC   = 64'hda3e39cb94b95bdb
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_valid,
  input  logic [63:0]        seed_state,
  input  logic [63:0]        seed_seq,
  output logic               seed_ready,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               rsp_valid,
  output logic [ID_W-1:0]    rsp_id,
  output logic [31:0]        rsp_data,
  output logic               busy,
  output logic [31:0]        gen_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SEED_A = 2'd1;
  localparam logic [1:0] SEED_B = 2'd2;
  localparam logic [1:0] SEED_C = 2'd3;

  logic [1:0]         fsm;
  logic [63:0]        state;
  logic [63:0]        inc;
  logic [63:0]        seed_lat;
  logic [ID_W-1:0]    ptr;
  logic [31:0]        gen_cnt_q;

  logic [63:0]        lcg_next;
  logic [31:0]        pcg_xs;
  logic [4:0]         pcg_rot;
  logic [31:0]        pcg_word;

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [ID_W-1:0]      off;
  logic [ID_W:0]        sum;
  logic [ID_W-1:0]      win;
  logic                 found;
  logic                 fire;

  assign lcg_next   = state * MULT + inc;
  assign busy       = (fsm != IDLE);
  assign seed_ready = (fsm == IDLE);
  assign gen_count  = gen_cnt_q;

  // Output permutation works on the pre-step state.
  always_comb begin
    pcg_xs   = 32'((((state >> 18) ^ state) >> 27));
    pcg_rot  = state[63:59];
    pcg_word = 32'({pcg_xs, pcg_xs} >> pcg_rot);
  end

  // Rotate the request vector so the pointer sits at bit 0, then pick the lowest set bit.
  always_comb begin
    req_dbl = {req, req};
    req_rot = NUM_REQ'(req_dbl >> ptr);
    off     = '0;
    found   = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off   = ID_W'(k);
        found = 1'b1;
      end
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (ID_W+1)'(NUM_REQ))
      sum = sum - (ID_W+1)'(NUM_REQ);
    win = sum[ID_W-1:0];
  end

  assign fire = (fsm == IDLE) && !seed_valid && found;
  assign gnt  = fire ? (NUM_REQ'(1) << win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= IDLE;
      state     <= RST_STATE;
      inc       <= RST_INC;
      seed_lat  <= '0;
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      gen_cnt_q <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (fsm)
        IDLE: begin
          if (seed_valid) begin
            state    <= '0;
            inc      <= (seed_seq << 1) | 64'd1;
            seed_lat <= seed_state;
            fsm      <= SEED_A;
          end else if (fire) begin
            state     <= lcg_next;
            ptr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + ID_W'(1);
            rsp_valid <= 1'b1;
            rsp_id    <= win;
            rsp_data  <= pcg_word;
            gen_cnt_q <= gen_cnt_q + 32'd1;
          end
        end
        SEED_A: begin
          state <= lcg_next;
          fsm   <= SEED_B;
        end
        SEED_B: begin
          state <= state + seed_lat;
          fsm   <= SEED_C;
        end
        default: begin
          state <= lcg_next;
          fsm   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pcg32_rng_arbiter.sv
// Directed plus random bench for pcg32_rng_arbiter against a C-style PCG32 reference model.
module tb_pcg32_rng_arbiter;

  localparam int          N         = 4;
  localparam logic [63:0] MULT      = 64'h5851f42d4c957f2d;
  localparam logic [63:0] RST_STATE = 64'h853c49e6748fea9b;
  localparam logic [63:0] RST_INC   = 64'hda3e39cb94b95bdb;

  logic         clk = 1'b0;
  logic         reset;
  logic         seed_valid;
  logic [63:0]  seed_state;
  logic [63:0]  seed_seq;
  logic         seed_ready;
  logic [N-1:0] req;
  logic [N-1:0] gnt;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         busy;
  logic [31:0]  gen_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: PCG state, pending seed countdown, round-robin pointer, expected outputs.
  logic [63:0] m_state;
  logic [63:0] m_inc;
  int          m_ptr;
  int          m_busy;
  logic        m_valid;
  logic [1:0]  m_id;
  logic [31:0] m_data;
  logic [31:0] m_gen;
  bit          last_served;
  int          last_win;
  logic [31:0] got_q[$];
  logic [31:0] exp42[6];

  always #5 clk = ~clk;

  pcg32_rng_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .seed_valid (seed_valid),
    .seed_state (seed_state),
    .seed_seq   (seed_seq),
    .seed_ready (seed_ready),
    .req        (req),
    .gnt        (gnt),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .busy       (busy),
    .gen_count  (gen_count)
  );

  function automatic logic [63:0] lcg(input logic [63:0] s, input logic [63:0] i);
    return s * MULT + i;
  endfunction

  function automatic logic [31:0] pcg_out(input logic [63:0] s);
    logic [31:0] xs;
    int          rot;
    xs  = 32'(((s >> 18) ^ s) >> 27);
    rot = int'(s[63:59]);
    return (xs >> rot) | (xs << ((32 - rot) % 32));
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = RST_STATE;
    m_inc   = RST_INC;
    m_ptr   = 0;
    m_busy  = 0;
    m_valid = 1'b0;
    m_id    = '0;
    m_data  = '0;
    m_gen   = '0;
  endtask

  task automatic step(input bit rst, input bit sv, input logic [63:0] ss,
                      input logic [63:0] sq, input logic [N-1:0] r);
    int           win;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    reset      = rst;
    seed_valid = sv;
    seed_state = ss;
    seed_seq   = sq;
    req        = r;
    #1;
    win = -1;
    for (int k = 0; k < N; k++)
      if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    exp_gnt = '0;
    if (m_busy == 0 && !sv && win >= 0) exp_gnt[win] = 1'b1;
    if (!rst) begin
      chk("gnt", 64'(gnt), 64'(exp_gnt));
      chk("busy", 64'(busy), 64'(m_busy != 0));
      chk("seed_ready", 64'(seed_ready), 64'(m_busy == 0));
    end
    last_served = 1'b0;
    if (rst) begin
      model_reset();
    end else if (m_busy > 0) begin
      m_busy--;
      m_valid = 1'b0;
    end else if (sv) begin
      // pcg32_srandom_r: state=0, inc=(seq<<1)|1, step, state+=initstate, step
      m_inc   = (sq << 1) | 64'd1;
      m_state = lcg(lcg(64'd0, m_inc) + ss, m_inc);
      m_busy  = 3;
      m_valid = 1'b0;
    end else if (win >= 0) begin
      m_valid     = 1'b1;
      m_id        = 2'(win);
      m_data      = pcg_out(m_state);
      m_state     = lcg(m_state, m_inc);
      m_ptr       = (win + 1) % N;
      m_gen       = m_gen + 32'd1;
      last_served = 1'b1;
      last_win    = win;
    end else begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", 64'(rsp_valid), 64'(m_valid));
    chk("rsp_id", 64'(rsp_id), 64'(m_id));
    chk("rsp_data", 64'(rsp_data), 64'(m_data));
    chk("gen_count", 64'(gen_count), 64'(m_gen));
    if (m_valid) got_q.push_back(rsp_data);
  endtask

  initial begin
    logic [N-1:0] pend;
    logic         sv_r;
    logic         rs_r;

    exp42[0] = 32'ha15c02b7; exp42[1] = 32'h7b47f409; exp42[2] = 32'hba1d3330;
    exp42[3] = 32'h83d2f293; exp42[4] = 32'hbfa4784b; exp42[5] = 32'hcbed606e;
    reset = 1'b1; seed_valid = 1'b0; seed_state = '0; seed_seq = '0; req = '0;
    model_reset();

    // Reset, then a single requester for three words.
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    repeat (3) step(0, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0, '0);
    chk("s1_gen_count", 64'(gen_count), 64'd3);

    // All four requesting from a fresh pointer: strict rotation.
    step(1, 0, 0, 0, '0);
    repeat (8) step(0, 0, 0, 0, 4'b1111);
    step(0, 0, 0, 0, '0);

    // Reseed with (42, 54) while two requesters wait.
    got_q.delete();
    step(0, 1, 64'd42, 64'd54, 4'b0110);
    repeat (3) step(0, 0, 0, 0, 4'b0110);
    repeat (6) step(0, 0, 0, 0, 4'b0110);
    chk("s3_words", 64'(got_q.size()), 64'd6);
    for (int k = 0; k < 6 && k < got_q.size(); k++)
      chk($sformatf("srandom42_54[%0d]", k), 64'(got_q[k]), 64'(exp42[k]));

    // Seed and request in the same cycle: seed wins, request served after SEED_C.
    step(0, 1, 64'h0123456789abcdef, 64'h0fedcba987654321, 4'b1000);
    repeat (3) step(0, 0, 0, 0, 4'b1000);
    step(0, 0, 0, 0, 4'b1000);
    chk("s4_served_id", 64'(rsp_id), 64'd3);
    step(0, 0, 0, 0, '0);

    // Reset during SEED_B aborts the seed; stream restarts from reset state.
    step(0, 1, 64'hdeadbeef, 64'h1234, '0);
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    got_q.delete();
    repeat (3) step(0, 0, 0, 0, 4'b0001);
    step(0, 0, 0, 0, '0);
    chk("s5_words", 64'(got_q.size()), 64'd3);

    // gen_count wraps.
    force dut.gen_cnt_q = 32'hFFFFFFFF;
    #1;
    release dut.gen_cnt_q;
    m_gen = 32'hFFFFFFFF;
    step(0, 0, 0, 0, 4'b0100);
    step(0, 0, 0, 0, '0);
    chk("gen_wrap", 64'(gen_count), 64'd0);

    // Random traffic: requesters hold until granted, occasional reseeds and resets.
    pend = '0;
    repeat (400) begin
      sv_r = ($urandom_range(0, 15) == 0);
      rs_r = ($urandom_range(0, 63) == 0);
      pend = pend | (N'($urandom) & N'($urandom));
      step(rs_r, sv_r, {$urandom, $urandom}, {$urandom, $urandom}, pend);
      if (last_served) pend[last_win] = ($urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
